// File: rtl/exc_ctrl.sv
// Exception / interrupt controller with a reloading timer.
// Holds the TH/TL/TCON timer registers and the EPC register, tracks an
// edge-detected external interrupt, and raises a combinational exception
// request toward the PC unit for illegal opcodes and interrupts taken in
// user mode.
module exc_ctrl #(
    parameter int TIMER_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] plus4,
    input  logic        illegal_op,
    input  logic        ext_irq,
    input  logic        wr_en,
    input  logic [1:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        exc_req,
    output logic [2:0]  exc_src,
    output logic [31:0] epc
);

    localparam logic [31:0] EPC_RESET = 32'h8000_0000;
    localparam logic [2:0]  SRC_NONE  = 3'b000;
    localparam logic [2:0]  SRC_ILL   = 3'b100;
    localparam logic [2:0]  SRC_IRQ   = 3'b101;

    logic [TIMER_W-1:0] th_q, th_d;
    logic [TIMER_W-1:0] tl_q, tl_d;
    logic               en_q, en_d;
    logic               ien_q, ien_d;
    logic               st_q, st_d;
    logic               pend_q, pend_d;
    logic               ext_prev_q;
    logic [31:0]        epc_q, epc_d;

    logic user_mode;
    logic reload;
    logic status_set;
    logic ext_rise;
    logic irq_req;
    logic irq_taken;

    assign user_mode  = ~pc[31];
    assign reload     = en_q & (&tl_q);
    assign status_set = reload & ien_q;
    assign ext_rise   = ext_irq & ~ext_prev_q;
    assign irq_req    = (st_q & ien_q) | pend_q;
    assign irq_taken  = (exc_src == SRC_IRQ);
    assign epc        = epc_q;

    // Exception select: illegal opcode beats interrupt; kernel mode masks both.
    always_comb begin
        exc_req = 1'b0;
        exc_src = SRC_NONE;
        if (user_mode && illegal_op) begin
            exc_req = 1'b1;
            exc_src = SRC_ILL;
        end else if (user_mode && irq_req) begin
            exc_req = 1'b1;
            exc_src = SRC_IRQ;
        end
    end

    // Next state: timer count/reload first, then bus writes override it.
    always_comb begin
        th_d  = th_q;
        tl_d  = tl_q;
        en_d  = en_q;
        ien_d = ien_q;
        st_d  = st_q | status_set;
        if (en_q) begin
            tl_d = reload ? th_q : tl_q + TIMER_W'(1);
        end
        if (wr_en) begin
            case (addr)
                2'd0: th_d = TIMER_W'(wr_data);
                2'd1: tl_d = TIMER_W'(wr_data);
                2'd2: begin
                    en_d  = wr_data[0];
                    ien_d = wr_data[1];
                    // A reload in the same cycle must not lose its status event.
                    st_d  = wr_data[2] | status_set;
                end
                default: ;  // EPC is read-only
            endcase
        end
        // A fresh rising edge is kept even if an interrupt is taken this cycle.
        pend_d = ext_rise | (pend_q & ~irq_taken);
        epc_d  = epc_q;
        if (exc_src == SRC_ILL) begin
            epc_d = plus4;
        end else if (exc_src == SRC_IRQ) begin
            epc_d = pc;
        end
    end

    // Register read mux.
    always_comb begin
        case (addr)
            2'd0:    rd_data = 32'(th_q);
            2'd1:    rd_data = 32'(tl_q);
            2'd2:    rd_data = {29'd0, st_q, ien_q, en_q};
            default: rd_data = epc_q;
        endcase
    end

    // State registers; reset discards all pending state immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q       <= '0;
            tl_q       <= '0;
            en_q       <= 1'b0;
            ien_q      <= 1'b0;
            st_q       <= 1'b0;
            pend_q     <= 1'b0;
            ext_prev_q <= 1'b0;
            epc_q      <= EPC_RESET;
        end else begin
            th_q       <= th_d;
            tl_q       <= tl_d;
            en_q       <= en_d;
            ien_q      <= ien_d;
            st_q       <= st_d;
            pend_q     <= pend_d;
            ext_prev_q <= ext_irq;
            epc_q      <= epc_d;
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Testbench for exc_ctrl: per-cycle vector table plus hand-built
// sequences for asynchronous reset, with expected values queued and
// compared as the DUT outputs become valid.
module tb_exc_ctrl;

    localparam logic [31:0] K = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] plus4;
    logic        illegal_op;
    logic        ext_irq;
    logic        wr_en;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        exc_req;
    logic [2:0]  exc_src;
    logic [31:0] epc;

    exc_ctrl #(.TIMER_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .plus4      (plus4),
        .illegal_op (illegal_op),
        .ext_irq    (ext_irq),
        .wr_en      (wr_en),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .exc_req    (exc_req),
        .exc_src    (exc_src),
        .epc        (epc)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        ill;
        logic        ext;
        logic        req;
        logic [2:0]  src;
        logic [31:0] rd;
        logic [31:0] epc;
    } vec_t;

    // mask bits: 0 exc_req, 1 exc_src, 2 rd_data, 3 epc
    typedef struct {
        int          id;
        logic [3:0]  mask;
        logic        req;
        logic [2:0]  src;
        logic [31:0] rd;
        logic [31:0] epc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t v(logic we, logic [1:0] a, logic [31:0] wd, logic [31:0] p,
                               logic ill, logic ext, logic req, logic [2:0] src,
                               logic [31:0] rd, logic [31:0] e);
        vec_t r;
        r.we = we; r.addr = a; r.wd = wd; r.pc = p; r.ill = ill; r.ext = ext;
        r.req = req; r.src = src; r.rd = rd; r.epc = e;
        return r;
    endfunction

    task automatic push_exp(int id, logic [3:0] mask, logic req, logic [2:0] src,
                            logic [31:0] rd, logic [31:0] e);
        exp_t x;
        x.id = id; x.mask = mask; x.req = req; x.src = src; x.rd = rd; x.epc = e;
        sb.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard empty: got none want one entry");
            return;
        end
        x = sb.pop_front();
        if (x.mask[0]) begin
            n_cmp++;
            if (exc_req !== x.req) begin
                n_bad++;
                $display("FAIL step%0d exc_req got %0b want %0b", x.id, exc_req, x.req);
            end
        end
        if (x.mask[1]) begin
            n_cmp++;
            if (exc_src !== x.src) begin
                n_bad++;
                $display("FAIL step%0d exc_src got %03b want %03b", x.id, exc_src, x.src);
            end
        end
        if (x.mask[2]) begin
            n_cmp++;
            if (rd_data !== x.rd) begin
                n_bad++;
                $display("FAIL step%0d rd_data got %08h want %08h", x.id, rd_data, x.rd);
            end
        end
        if (x.mask[3]) begin
            n_cmp++;
            if (epc !== x.epc) begin
                n_bad++;
                $display("FAIL step%0d epc got %08h want %08h", x.id, epc, x.epc);
            end
        end
    endtask

    task automatic drive(logic we, logic [1:0] a, logic [31:0] wd, logic [31:0] p,
                         logic ill, logic ext);
        wr_en = we; addr = a; wr_data = wd; pc = p; plus4 = p + 32'd4;
        illegal_op = ill; ext_irq = ext;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, register setup, timer reload with interrupt
        vecs.push_back(v(0, 0, 0,            K,       0, 0, 0, 3'b000, 32'h0,        K));
        vecs.push_back(v(0, 3, 0,            K,       0, 0, 0, 3'b000, K,            K));
        vecs.push_back(v(0, 2, 0,            K,       0, 0, 0, 3'b000, 32'h0,        K));
        vecs.push_back(v(0, 1, 0,            32'h100, 1, 0, 1, 3'b100, 32'h0,        K));
        vecs.push_back(v(0, 3, 0,            K,       0, 0, 0, 3'b000, 32'h104,      32'h104));
        vecs.push_back(v(1, 0, 32'hFFFFFFFD, K,       0, 0, 0, 3'b000, 32'h0,        32'h104));
        vecs.push_back(v(1, 1, 32'hFFFFFFFE, K,       0, 0, 0, 3'b000, 32'h0,        32'h104));
        vecs.push_back(v(1, 2, 32'h3,        K,       0, 0, 0, 3'b000, 32'h0,        32'h104));
        vecs.push_back(v(0, 1, 0,            32'h40,  0, 0, 0, 3'b000, 32'hFFFFFFFE, 32'h104));
        vecs.push_back(v(0, 1, 0,            32'h40,  0, 0, 0, 3'b000, 32'hFFFFFFFF, 32'h104));
        vecs.push_back(v(0, 1, 0,            32'h40,  0, 0, 1, 3'b101, 32'hFFFFFFFD, 32'h104));
        vecs.push_back(v(0, 3, 0,            K,       0, 0, 0, 3'b000, 32'h40,       32'h40));
        vecs.push_back(v(0, 2, 0,            K,       0, 0, 0, 3'b000, 32'h7,        32'h40));
        vecs.push_back(v(0, 1, 0,            K,       0, 0, 0, 3'b000, 32'hFFFFFFFD, 32'h40));
        // Illegal op over pending timer interrupt, then interrupt taken
        vecs.push_back(v(0, 1, 0,            32'h100, 1, 0, 1, 3'b100, 32'hFFFFFFFE, 32'h40));
        vecs.push_back(v(0, 3, 0,            32'h200, 0, 0, 1, 3'b101, 32'h104,      32'h104));
        vecs.push_back(v(0, 3, 0,            K,       0, 0, 0, 3'b000, 32'h200,      32'h200));
        // Write clearing TCON on a reload cycle keeps status
        vecs.push_back(v(0, 1, 0,            K,       0, 0, 0, 3'b000, 32'hFFFFFFFE, 32'h200));
        vecs.push_back(v(1, 2, 0,            K,       0, 0, 0, 3'b000, 32'h7,        32'h200));
        vecs.push_back(v(0, 2, 0,            K,       0, 0, 0, 3'b000, 32'h4,        32'h200));
        vecs.push_back(v(0, 1, 0,            32'h300, 0, 0, 0, 3'b000, 32'hFFFFFFFD, 32'h200));
        vecs.push_back(v(1, 2, 0,            K,       0, 0, 0, 3'b000, 32'h4,        32'h200));
        vecs.push_back(v(1, 3, 32'h12345678, K,       0, 0, 0, 3'b000, 32'h200,      32'h200));
        vecs.push_back(v(0, 3, 0,            K,       0, 0, 0, 3'b000, 32'h200,      32'h200));
        // TL write beats count
        vecs.push_back(v(1, 2, 32'h1,        K,       0, 0, 0, 3'b000, 32'h0,        32'h200));
        vecs.push_back(v(0, 1, 0,            K,       0, 0, 0, 3'b000, 32'hFFFFFFFD, 32'h200));
        vecs.push_back(v(1, 1, 32'h10,       K,       0, 0, 0, 3'b000, 32'hFFFFFFFE, 32'h200));
        vecs.push_back(v(0, 1, 0,            K,       0, 0, 0, 3'b000, 32'h10,       32'h200));
        vecs.push_back(v(1, 2, 0,            K,       0, 0, 0, 3'b000, 32'h1,        32'h200));
        vecs.push_back(v(0, 1, 0,            K,       0, 0, 0, 3'b000, 32'h12,       32'h200));
        // External interrupt edge, kernel masking, priority
        vecs.push_back(v(0, 2, 0,            32'h80000010, 1, 1, 0, 3'b000, 32'h0,   32'h200));
        vecs.push_back(v(0, 2, 0,            K,       1, 1, 0, 3'b000, 32'h0,        32'h200));
        vecs.push_back(v(0, 3, 0,            32'h20,  0, 1, 1, 3'b101, 32'h200,      32'h200));
        vecs.push_back(v(0, 3, 0,            32'h30,  0, 1, 0, 3'b000, 32'h20,       32'h20));
        vecs.push_back(v(0, 3, 0,            32'h30,  0, 0, 0, 3'b000, 32'h20,       32'h20));
        vecs.push_back(v(0, 3, 0,            K,       0, 1, 0, 3'b000, 32'h20,       32'h20));
        vecs.push_back(v(0, 3, 0,            32'h40,  1, 1, 1, 3'b100, 32'h20,       32'h20));
        vecs.push_back(v(0, 3, 0,            32'h50,  0, 0, 1, 3'b101, 32'h44,       32'h44));
        vecs.push_back(v(0, 3, 0,            32'h50,  0, 0, 0, 3'b000, 32'h50,       32'h50));

        // Values while held in reset: request follows inputs only
        reset = 1'b1;
        drive(0, 0, 0, 32'h10, 1, 0);
        #3;
        push_exp(900, 4'b1111, 1'b1, 3'b100, 32'h0, K);
        check_out();
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, K, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].pc, vecs[i].ill, vecs[i].ext);
            push_exp(i, 4'b1111, vecs[i].req, vecs[i].src, vecs[i].rd, vecs[i].epc);
            #1;
            check_out();
        end

        // Asynchronous reset while counting with ext_pend set
        @(negedge clk);
        drive(1, 2, 32'h1, K, 0, 0);
        @(negedge clk);
        drive(0, 1, 0, K, 0, 1);
        @(negedge clk);
        drive(0, 1, 0, 32'h60, 0, 1);
        push_exp(1000, 4'b0011, 1'b1, 3'b101, 32'h0, 32'h0);
        #1 check_out();
        #1 pc = K;
        #1 reset = 1'b1;
        #1 begin pc = 32'h60; plus4 = 32'h64; addr = 2'd1; end
        push_exp(1001, 4'b1111, 1'b0, 3'b000, 32'h0, K);
        #1 check_out();
        #1 addr = 2'd2;
        push_exp(1002, 4'b0100, 1'b0, 3'b000, 32'h0, 32'h0);
        #1 check_out();
        #1 addr = 2'd0;
        push_exp(1003, 4'b0100, 1'b0, 3'b000, 32'h0, 32'h0);
        #1 check_out();

        // Edge history cleared by reset: held-high ext_irq registers as a new edge
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1, 0, K, 0, 1);
        @(negedge clk);
        drive(0, 1, 0, 32'h70, 0, 1);
        push_exp(1004, 4'b1111, 1'b1, 3'b101, 32'h0, K);
        #1 check_out();
        @(negedge clk);
        drive(0, 0, 0, K, 0, 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
